// File: rtl/vgroup_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vgroup_seq_ctrl
// Brief    : Walks the LMUL register group of one vector instruction, issuing
//            one register per beat with source/destination indices, a
//            remaining-beat count and a byte-lane tail mask. Signals done on
//            completion and err on illegal vl/vtype/base configurations.
// Options  : VGSEQ_STALL_CNT_EN - builds a saturating issue-stall counter;
//            when undefined stall_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module vgroup_seq_ctrl #(
    parameter int VLEN      = 64,
    parameter int REG_IDX_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_vl,
    input  logic [6:0]            cmd_vtype,
    input  logic [REG_IDX_W-1:0]  cmd_vs1,
    input  logic [REG_IDX_W-1:0]  cmd_vs2,
    input  logic [REG_IDX_W-1:0]  cmd_vd,
    output logic                  iss_valid,
    input  logic                  iss_ready,
    output logic [REG_IDX_W-1:0]  iss_vs1,
    output logic [REG_IDX_W-1:0]  iss_vs2,
    output logic [REG_IDX_W-1:0]  iss_vd,
    output logic [3:0]            iss_remaining,
    output logic [VLEN/8-1:0]     iss_bytemask,
    output logic                  iss_last,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           stall_cnt
);

    localparam int BYTES    = VLEN / 8;
    localparam int NUM_REGS = 1 << REG_IDX_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_ISSUE  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_nxt;

    // Captured instruction
    logic [7:0]           vl_q;
    logic [2:0]           vsew_q;
    logic [2:0]           vlmul_q;
    logic [REG_IDX_W-1:0] vs1_q;
    logic [REG_IDX_W-1:0] vs2_q;
    logic [REG_IDX_W-1:0] vd_q;

    // Per-instruction issue bookkeeping, set up in CHECK
    logic [3:0]           beat;
    logic [3:0]           n_q;
    logic [BYTES-1:0]     last_mask_q;

    // vtype bit 6 (vta/vma-style policy bit) has no effect on sequencing
    logic unused_vtype_msb;
    assign unused_vtype_msb = cmd_vtype[6];

    // Element geometry; low two bits suffice because larger encodings are
    // rejected separately through the illegal flag.
    logic [3:0]  epr;
    logic [3:0]  lmul;
    logic [7:0]  vlmax;
    logic [8:0]  vl_round;
    logic [3:0]  n_calc;
    logic [3:0]  last_bytes;
    logic [BYTES-1:0] mask_calc;
    logic        bad_vtype;
    logic        bad_vl;
    logic        bad_align;
    logic        bad_range;
    logic        illegal;
    logic        is_last_beat;

    assign epr        = 4'd8 >> vsew_q[1:0];
    assign lmul       = 4'd1 << vlmul_q[1:0];
    assign vlmax      = {4'b0, epr} << vlmul_q[1:0];
    // ceil(vl / EPR) as a shift, since EPR is a power of two
    assign vl_round   = {1'b0, vl_q} + {5'b0, epr} - 9'd1;
    assign n_calc     = 4'(vl_round >> (2'd3 - vsew_q[1:0]));
    // Bytes occupied in the final register: total bytes minus full registers
    assign last_bytes = 4'((11'(vl_q) << vsew_q[1:0]) - (11'(n_calc - 4'd1) << 3));
    assign mask_calc  = {BYTES{1'b1}} >> (4'(BYTES) - last_bytes);

    assign bad_vtype  = (vsew_q > 3'd3) || (vlmul_q > 3'd3);
    assign bad_vl     = (vl_q > vlmax);
    assign bad_align  = ((vs1_q & REG_IDX_W'(lmul - 4'd1)) != '0) ||
                        ((vs2_q & REG_IDX_W'(lmul - 4'd1)) != '0) ||
                        ((vd_q  & REG_IDX_W'(lmul - 4'd1)) != '0);
    assign bad_range  = (({1'b0, vs1_q} + (REG_IDX_W+1)'(lmul)) > (REG_IDX_W+1)'(NUM_REGS)) ||
                        (({1'b0, vs2_q} + (REG_IDX_W+1)'(lmul)) > (REG_IDX_W+1)'(NUM_REGS)) ||
                        (({1'b0, vd_q}  + (REG_IDX_W+1)'(lmul)) > (REG_IDX_W+1)'(NUM_REGS));
    assign illegal    = bad_vtype || bad_vl || bad_align || bad_range;

    assign is_last_beat = (beat == (n_q - 4'd1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (illegal) begin
                    state_nxt = ST_IDLE;
                end else if (vl_q == 8'd0) begin
                    state_nxt = ST_FINISH;
                end else begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (iss_ready && is_last_beat) begin
                    state_nxt = ST_FINISH;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs: beat fields are driven only in ISSUE, zero elsewhere
    always_comb begin
        cmd_ready     = (state == ST_IDLE);
        iss_valid     = 1'b0;
        iss_vs1       = '0;
        iss_vs2       = '0;
        iss_vd        = '0;
        iss_remaining = 4'd0;
        iss_bytemask  = '0;
        iss_last      = 1'b0;
        done          = (state == ST_FINISH);
        err           = (state == ST_CHECK) && illegal;
        if (state == ST_ISSUE) begin
            iss_valid     = 1'b1;
            iss_vs1       = vs1_q + REG_IDX_W'(beat);
            iss_vs2       = vs2_q + REG_IDX_W'(beat);
            iss_vd        = vd_q  + REG_IDX_W'(beat);
            iss_remaining = n_q - beat;
            iss_bytemask  = is_last_beat ? last_mask_q : {BYTES{1'b1}};
            iss_last      = is_last_beat;
        end
    end

    // Command capture, per-instruction setup and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vl_q        <= 8'd0;
            vsew_q      <= 3'd0;
            vlmul_q     <= 3'd0;
            vs1_q       <= '0;
            vs2_q       <= '0;
            vd_q        <= '0;
            beat        <= 4'd0;
            n_q         <= 4'd0;
            last_mask_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        vl_q    <= cmd_vl;
                        vsew_q  <= cmd_vtype[5:3];
                        vlmul_q <= cmd_vtype[2:0];
                        vs1_q   <= cmd_vs1;
                        vs2_q   <= cmd_vs2;
                        vd_q    <= cmd_vd;
                    end
                end
                ST_CHECK: begin
                    beat        <= 4'd0;
                    n_q         <= n_calc;
                    last_mask_q <= mask_calc;
                end
                ST_ISSUE: begin
                    if (iss_ready && !is_last_beat) begin
                        beat <= beat + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef VGSEQ_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of cycles where a beat waits on the datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
        end else if ((state == ST_IDLE) && cmd_valid) begin
            stall_q <= 16'h0000;
        end else if (iss_valid && !iss_ready && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vgroup_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vgroup_seq_ctrl
// Brief    : Directed self-checking bench for vgroup_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vgroup_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_vl;
    logic [6:0]  cmd_vtype;
    logic [4:0]  cmd_vs1;
    logic [4:0]  cmd_vs2;
    logic [4:0]  cmd_vd;
    logic        iss_valid;
    logic        iss_ready;
    logic [4:0]  iss_vs1;
    logic [4:0]  iss_vs2;
    logic [4:0]  iss_vd;
    logic [3:0]  iss_remaining;
    logic [7:0]  iss_bytemask;
    logic        iss_last;
    logic        done;
    logic        err;
    logic [15:0] stall_cnt;

    int total;
    int bad;

`ifdef VGSEQ_STALL_CNT_EN
    localparam logic [15:0] EXP_STALL = 16'd3;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    vgroup_seq_ctrl #(.VLEN(64), .REG_IDX_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_vl        (cmd_vl),
        .cmd_vtype     (cmd_vtype),
        .cmd_vs1       (cmd_vs1),
        .cmd_vs2       (cmd_vs2),
        .cmd_vd        (cmd_vd),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_vs1       (iss_vs1),
        .iss_vs2       (iss_vs2),
        .iss_vd        (iss_vd),
        .iss_remaining (iss_remaining),
        .iss_bytemask  (iss_bytemask),
        .iss_last      (iss_last),
        .done          (done),
        .err           (err),
        .stall_cnt     (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is short and fixed-length
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for exactly one accepting cycle; returns in CHECK
    task automatic send_cmd(input logic [7:0] vl, input logic [2:0] vsew, input logic [2:0] vlmul,
                            input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd);
        chk("cmd_ready_before", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_vl    = vl;
        cmd_vtype = {1'b0, vsew, vlmul};
        cmd_vs1   = vs1;
        cmd_vs2   = vs2;
        cmd_vd    = vd;
        step();
        cmd_valid = 1'b0;
        chk("cmd_ready_check", cmd_ready, 0);
        chk("iss_valid_check", iss_valid, 0);
    endtask

    // Check the presented beat, then advance one cycle
    task automatic expect_beat(input string tag, input logic [4:0] vs1, input logic [4:0] vs2,
                               input logic [4:0] vd, input logic [3:0] rem,
                               input logic [7:0] mask, input logic last);
        chk({tag, "_valid"}, iss_valid, 1);
        chk({tag, "_vs1"},   iss_vs1, vs1);
        chk({tag, "_vs2"},   iss_vs2, vs2);
        chk({tag, "_vd"},    iss_vd, vd);
        chk({tag, "_rem"},   iss_remaining, rem);
        chk({tag, "_mask"},  iss_bytemask, mask);
        chk({tag, "_last"},  iss_last, last);
        chk({tag, "_done"},  done, 0);
        step();
    endtask

    task automatic expect_illegal(input string tag);
        chk({tag, "_err"},   err, 1);
        chk({tag, "_done"},  done, 0);
        step();
        chk({tag, "_err_off"}, err, 0);
        chk({tag, "_ready"}, cmd_ready, 1);
        chk({tag, "_novalid"}, iss_valid, 0);
        step();
        chk({tag, "_novalid2"}, iss_valid, 0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_vl    = 8'd0;
        cmd_vtype = 7'd0;
        cmd_vs1   = 5'd0;
        cmd_vs2   = 5'd0;
        cmd_vd    = 5'd0;
        iss_ready = 1'b1;

        step();
        step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_fields", {iss_vs1, iss_vs2, iss_vd, iss_remaining, iss_last}, 0);
        chk("rst_mask", iss_bytemask, 0);
        chk("rst_stall", stall_cnt, 0);
        rst_n = 1'b1;
        step();

        // Single beat, full register
        send_cmd(8'd8, 3'd0, 3'd0, 5'd2, 5'd3, 5'd4);
        step();
        expect_beat("t1", 5'd2, 5'd3, 5'd4, 4'd1, 8'hFF, 1'b1);
        chk("t1_done", done, 1);
        chk("t1_novalid", iss_valid, 0);
        step();
        chk("t1_done_off", done, 0);
        chk("t1_ready", cmd_ready, 1);

        // Four beats, SEW=16, tail of 1 element (2 bytes)
        send_cmd(8'd13, 3'd1, 3'd2, 5'd8, 5'd12, 5'd16);
        step();
        expect_beat("t2b0", 5'd8,  5'd12, 5'd16, 4'd4, 8'hFF, 1'b0);
        expect_beat("t2b1", 5'd9,  5'd13, 5'd17, 4'd3, 8'hFF, 1'b0);
        expect_beat("t2b2", 5'd10, 5'd14, 5'd18, 4'd2, 8'hFF, 1'b0);
        expect_beat("t2b3", 5'd11, 5'd15, 5'd19, 4'd1, 8'h03, 1'b1);
        chk("t2_done", done, 1);
        step();

        // LMUL=8 but only one register populated
        send_cmd(8'd5, 3'd0, 3'd3, 5'd0, 5'd8, 5'd16);
        step();
        expect_beat("t3", 5'd0, 5'd8, 5'd16, 4'd1, 8'h1F, 1'b1);
        chk("t3_done", done, 1);
        chk("t3_novalid", iss_valid, 0);
        step();

        // Illegal: vl above VLMAX, fractional LMUL, misaligned destination
        send_cmd(8'd9, 3'd3, 3'd3, 5'd0, 5'd8, 5'd16);
        expect_illegal("ill_vl");
        send_cmd(8'd1, 3'd0, 3'd5, 5'd0, 5'd0, 5'd0);
        expect_illegal("ill_lmul");
        send_cmd(8'd4, 3'd0, 3'd1, 5'd0, 5'd2, 5'd3);
        expect_illegal("ill_align");

        // Zero-length: done two cycles after acceptance, no beats
        send_cmd(8'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        chk("vl0_done_early", done, 0);
        step();
        chk("vl0_done", done, 1);
        chk("vl0_novalid", iss_valid, 0);
        step();
        chk("vl0_done_off", done, 0);
        chk("vl0_ready", cmd_ready, 1);

        // Back-pressure on beat 0 for three cycles
        iss_ready = 1'b0;
        send_cmd(8'd16, 3'd0, 3'd1, 5'd2, 5'd4, 5'd6);
        step();
        for (int k = 0; k < 3; k++) begin
            chk("st_valid", iss_valid, 1);
            chk("st_fields", {iss_vs1, iss_vs2, iss_vd, iss_remaining, iss_last},
                {5'd2, 5'd4, 5'd6, 4'd2, 1'b0});
            chk("st_mask", iss_bytemask, 8'hFF);
            step();
        end
        chk("st_hold_vs1", iss_vs1, 5'd2);
        chk("st_cnt", stall_cnt, EXP_STALL);
        iss_ready = 1'b1;
        step();
        expect_beat("st_b1", 5'd3, 5'd5, 5'd7, 4'd1, 8'hFF, 1'b1);
        chk("st_done", done, 1);
        chk("st_cnt_after", stall_cnt, EXP_STALL);
        step();

        // Reset while beat 0 is stalled
        iss_ready = 1'b0;
        send_cmd(8'd16, 3'd0, 3'd1, 5'd2, 5'd4, 5'd6);
        chk("rs_cnt_cleared", stall_cnt, 0);
        step();
        chk("rs_valid_pre", iss_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_valid_now", iss_valid, 0);
        chk("rs_ready_now", cmd_ready, 1);
        chk("rs_stall_now", stall_cnt, 0);
        step();
        rst_n = 1'b1;
        iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("rs_no_done", {done, err, iss_valid}, 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
